// File: rtl/tone_seq_pkg.sv
// tone_seq_pkg: shared state encoding and field widths for the tone sequencer
package tone_seq_pkg;
  localparam int K_W = 21;
  localparam int DUR_W = 16;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler emitting a one-cycle tick every DIV cycles, with synchronous clear
module tick_gen #(
  parameter int DIV = 10,
  localparam int W = DIV > 1 ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(DIV - 1);
  // wrap after each tick; a clear restarts the phase so the next period is whole
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
  // prescaler register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a table of divisor/duration notes with silent gaps into a clock divider
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int DEPTH = 16,
  parameter int GAP_TICKS = 10,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [K_W-1:0]   wr_k,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic             busy,
  output logic             done,
  output logic [K_W-1:0]   k_out,
  output logic             div_rstn,
  output logic [AW-1:0]    note_idx
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_TICKS > 0 ? GAP_TICKS - 1 : 0);
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [K_W-1:0] k_q, k_d;
  logic [DUR_W-1:0] dur_q, dur_d, tcnt_q, tcnt_d;
  logic [K_W+DUR_W-1:0] tbl_q [DEPTH];
  logic [K_W-1:0] rd_k;
  logic [DUR_W-1:0] rd_dur;
  logic tick, clr, play_end, gap_end, adv, last, eos;
  assign {rd_k, rd_dur} = tbl_q[idx_q];
  assign play_end = state_q == S_PLAY && tick && tcnt_q == dur_q - DUR_W'(1);
  assign gap_end = state_q == S_GAP && tick && tcnt_q == GAP_LAST;
  assign adv = GAP_TICKS == 0 ? play_end : gap_end;
  assign last = idx_q == AW'(DEPTH - 1);
  assign eos = (state_q == S_LOAD && rd_dur == '0) || (adv && last);
  assign clr = state_d != state_q;
  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk (clkin),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );
  // note table: written in any state, only read back on LOAD
  always_ff @(posedge clkin) if (wr_en) tbl_q[wr_addr] <= {wr_k, wr_dur};
  // sequencing decisions; stop outranks everything, including a same-cycle note end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    k_d = state_q == S_LOAD ? rd_k : k_q;
    dur_d = state_q == S_LOAD ? rd_dur : dur_q;
    tcnt_d = clr ? '0 : tcnt_q + DUR_W'(tick);
    if (stop && state_q != S_IDLE) state_d = S_IDLE;
    else if (state_q == S_IDLE && start) begin
      state_d = S_LOAD;
      idx_d = '0;
    end else if (eos) begin
      state_d = loop ? S_LOAD : S_DONE;
      idx_d = loop ? '0 : idx_q;
    end else if (adv) begin
      state_d = S_LOAD;
      idx_d = idx_q + AW'(1);
    end else if (state_q == S_LOAD) state_d = S_PLAY;
    else if (play_end) state_d = S_GAP;
    else if (state_q == S_DONE) state_d = S_IDLE;
  end
  // state, note and tick-count registers
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      k_q <= '0;
      dur_q <= '0;
      tcnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      k_q <= k_d;
      dur_q <= dur_d;
      tcnt_q <= tcnt_d;
    end
  end
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign div_rstn = state_q == S_PLAY && k_q != '0;
  assign k_out = k_q;
  assign note_idx = idx_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed checks of playback timing, looping, rests, stop and reset
module tb_tone_sequencer;
  logic clkin = 1'b0, rst = 1'b1, wr_en = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [20:0] wr_k = '0;
  logic [15:0] wr_dur = '0;
  logic busy, done, div_rstn;
  logic [20:0] k_out;
  logic [1:0] note_idx;
  int total = 0, bad = 0;

  tone_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .DEPTH(4), .GAP_TICKS(1)) dut (
    .clkin(clkin), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_k(wr_k),
    .wr_dur(wr_dur), .start(start), .stop(stop), .loop(loop), .busy(busy),
    .done(done), .k_out(k_out), .div_rstn(div_rstn), .note_idx(note_idx)
  );

  initial forever #5 clkin = ~clkin;

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [20:0] k, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_k = k; wr_dur = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_song();
    write_entry(2'd0, 21'd5, 16'd3);
    write_entry(2'd1, 21'd7, 16'd2);
    write_entry(2'd2, 21'd0, 16'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || k_out !== 21'd0 || div_rstn !== 1'b0 || note_idx !== 2'd0) begin
      bad++;
      $display("FAIL reset busy=%b done=%b k=%0d div=%b idx=%0d want all zero", busy, done, k_out, div_rstn, note_idx);
    end
  endtask

  task automatic test_basic();
    logic exp_div, exp_busy, exp_done;
    logic [20:0] exp_k;
    load_song();
    loop = 1'b0;
    pulse_start();
    total++;
    if (busy !== 1'b1 || note_idx !== 2'd0 || div_rstn !== 1'b0) begin
      bad++;
      $display("FAIL basic_load busy=%b idx=%0d div=%b want busy=1 idx=0 div=0", busy, note_idx, div_rstn);
    end
    for (int n = 2; n <= 76; n++) begin
      tick();
      exp_div = (n >= 2 && n <= 31) || (n >= 43 && n <= 62);
      exp_k = n <= 41 ? 21'd5 : 21'd7;
      exp_busy = n <= 74;
      exp_done = n == 74;
      total++;
      if (div_rstn !== exp_div || busy !== exp_busy || done !== exp_done || (exp_div && k_out !== exp_k)) begin
        bad++;
        $display("FAIL basic n=%0d div=%b busy=%b done=%b k=%0d want div=%b busy=%b done=%b k=%0d",
                 n, div_rstn, busy, done, k_out, exp_div, exp_busy, exp_done, exp_k);
      end
      if (n == 42) begin
        total++;
        if (note_idx !== 2'd1) begin
          bad++;
          $display("FAIL basic_idx n=42 idx=%0d want 1", note_idx);
        end
      end
    end
  endtask

  task automatic test_loop();
    logic [1:0] exp_idx;
    load_song();
    loop = 1'b1;
    pulse_start();
    for (int n = 2; n <= 150; n++) begin
      tick();
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL loop_done n=%0d done=%b want 0", n, done);
      end
      if (n == 10 || n == 50 || n == 83 || n == 123) begin
        exp_idx = (n == 50 || n == 123) ? 2'd1 : 2'd0;
        total++;
        if (note_idx !== exp_idx || div_rstn !== 1'b1) begin
          bad++;
          $display("FAIL loop_idx n=%0d idx=%0d div=%b want idx=%0d div=1", n, note_idx, div_rstn, exp_idx);
        end
      end
    end
    total++;
    if (div_rstn !== 1'b1) begin
      bad++;
      $display("FAIL loop_prestop div=%b want 1", div_rstn);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop = 1'b0;
    total++;
    if (busy !== 1'b0 || div_rstn !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL loop_stop busy=%b div=%b done=%b want 0 0 0", busy, div_rstn, done);
    end
  endtask

  task automatic test_rest();
    logic exp_div, exp_busy, exp_done;
    write_entry(2'd0, 21'd0, 16'd2);
    write_entry(2'd1, 21'd5, 16'd1);
    write_entry(2'd2, 21'd0, 16'd0);
    loop = 1'b0;
    pulse_start();
    for (int n = 2; n <= 56; n++) begin
      tick();
      exp_div = n >= 33 && n <= 42;
      exp_busy = n <= 54;
      exp_done = n == 54;
      total++;
      if (div_rstn !== exp_div || busy !== exp_busy || done !== exp_done) begin
        bad++;
        $display("FAIL rest n=%0d div=%b busy=%b done=%b want div=%b busy=%b done=%b",
                 n, div_rstn, busy, done, exp_div, exp_busy, exp_done);
      end
      if (n == 32) begin
        total++;
        if (note_idx !== 2'd1) begin
          bad++;
          $display("FAIL rest_idx idx=%0d want 1", note_idx);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic exp_div, exp_busy, exp_done;
    logic [1:0] exp_idx;
    logic [20:0] exp_k;
    int seg, pos;
    write_entry(2'd0, 21'd1, 16'd1);
    write_entry(2'd1, 21'd2, 16'd1);
    write_entry(2'd2, 21'd3, 16'd1);
    write_entry(2'd3, 21'd4, 16'd1);
    loop = 1'b0;
    pulse_start();
    for (int n = 2; n <= 87; n++) begin
      tick();
      seg = (n - 1) / 21;
      pos = (n - 1) % 21;
      exp_busy = n <= 85;
      exp_done = n == 85;
      exp_div = n <= 84 && pos >= 1 && pos <= 10;
      exp_idx = 2'(seg);
      exp_k = 21'(seg + 1);
      total++;
      if (busy !== exp_busy || done !== exp_done || div_rstn !== exp_div ||
          (n <= 84 && note_idx !== exp_idx) || (exp_div && k_out !== exp_k)) begin
        bad++;
        $display("FAIL wrap n=%0d busy=%b done=%b div=%b idx=%0d k=%0d want busy=%b done=%b div=%b idx=%0d k=%0d",
                 n, busy, done, div_rstn, note_idx, k_out, exp_busy, exp_done, exp_div, exp_idx, exp_k);
      end
    end
  endtask

  task automatic test_rst_mid();
    pulse_start();
    for (int n = 2; n <= 5; n++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (div_rstn !== 1'b1 || note_idx !== 2'd0 || k_out !== 21'd1) begin
      bad++;
      $display("FAIL busy_start div=%b idx=%0d k=%0d want div=1 idx=0 k=1", div_rstn, note_idx, k_out);
    end
    tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || k_out !== 21'd0 || div_rstn !== 1'b0 || note_idx !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset busy=%b done=%b k=%0d div=%b idx=%0d want all zero", busy, done, k_out, div_rstn, note_idx);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL post_reset n=%0d busy=%b done=%b want 0 0", n, busy, done);
      end
    end
  endtask

  task automatic test_write_during_play();
    load_song();
    loop = 1'b1;
    pulse_start();
    for (int n = 2; n <= 10; n++) tick();
    wr_en = 1'b1; wr_addr = 2'd0; wr_k = 21'd9; wr_dur = 16'd3;
    tick();
    wr_en = 1'b0;
    total++;
    if (k_out !== 21'd5 || div_rstn !== 1'b1) begin
      bad++;
      $display("FAIL wr_now k=%0d div=%b want k=5 div=1", k_out, div_rstn);
    end
    for (int n = 12; n <= 31; n++) tick();
    total++;
    if (k_out !== 21'd5 || div_rstn !== 1'b1) begin
      bad++;
      $display("FAIL wr_end k=%0d div=%b want k=5 div=1", k_out, div_rstn);
    end
    for (int n = 32; n <= 80; n++) tick();
    total++;
    if (k_out !== 21'd9 || div_rstn !== 1'b1 || note_idx !== 2'd0) begin
      bad++;
      $display("FAIL wr_next k=%0d div=%b idx=%0d want k=9 div=1 idx=0", k_out, div_rstn, note_idx);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop = 1'b0;
    total++;
    if (busy !== 1'b0 || div_rstn !== 1'b0) begin
      bad++;
      $display("FAIL wr_stop busy=%b div=%b want 0 0", busy, div_rstn);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loop();
    test_rest();
    test_wrap();
    test_rst_mid();
    test_write_during_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
